mips_bus_initiator: RTL

//   CPU-side initiator for the 32-bit memory bus (address/read/write/byteenable/waitrequest).

---
 rtl/mips_bus_initiator.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_bus_initiator.sv
// CPU-side initiator for the 32-bit memory bus: one request at a time, waitrequest stalls,
// byte-lane alignment on stores, lane extraction plus zero/sign extension on loads.
module mips_bus_initiator #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    localparam logic [31:0] LAST_STALL = (TIMEOUT == 0) ? '0 : 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] address_q, address_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        rvalid_q, rvalid_d;
    logic        rerr_q, rerr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        illegal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    // Request decode: legality, lane enables and lane-placed store data.
    always_comb begin
        illegal   = 1'b0;
        be_new    = 4'b1111;
        wdata_new = req_wdata;
        case (req_size)
            2'd0: begin
                be_new    = 4'b0001 << req_addr[1:0];
                wdata_new = 32'(req_wdata[7:0]) << {req_addr[1:0], 3'b000};
            end
            2'd1: begin
                illegal   = req_addr[0];
                be_new    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_new = 32'(req_wdata[15:0]) << {req_addr[1], 4'b0000};
            end
            2'd2: illegal = (req_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Load return path: shift the addressed lane(s) down, then extend.
    always_comb begin
        rd_shifted = '0;
        rd_ext     = readdata;
        case (size_q)
            2'd0: begin
                rd_shifted = readdata >> {lane_q, 3'b000};
                rd_ext     = {{24{sgn_q & rd_shifted[7]}}, rd_shifted[7:0]};
            end
            2'd1: begin
                rd_shifted = readdata >> {lane_q[1], 4'b0000};
                rd_ext     = {{16{sgn_q & rd_shifted[15]}}, rd_shifted[15:0]};
            end
            default: rd_ext = readdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        sgn_d     = sgn_q;
        size_d    = size_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        rvalid_d  = 1'b0;
        rerr_d    = 1'b0;
        rdata_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d   = req_write;
                    sgn_d  = req_signed;
                    size_d = req_size;
                    lane_d = req_addr[1:0];
                    if (illegal) begin
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        address_d = {req_addr[31:2], 2'b00};
                        be_d      = be_new;
                        wdata_d   = wdata_new;
                        read_d    = ~req_write;
                        write_d   = req_write;
                        cnt_d     = '0;
                    end
                end
            end
            S_REQ: begin
                if (waitrequest) begin
                    if (TIMEOUT != 0 && cnt_q == LAST_STALL) begin
                        read_d   = 1'b0;
                        write_d  = 1'b0;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (wr_q) begin
                        rvalid_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_RDATA;
                    end
                end
            end
            S_RDATA: begin
                rvalid_d = 1'b1;
                rdata_d  = rd_ext;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= '0;
            lane_q    <= '0;
            cnt_q     <= '0;
            address_q <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            sgn_q     <= sgn_d;
            size_q    <= size_d;
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = rvalid_q;
    assign resp_err   = rerr_q;
    assign resp_rdata = rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;

endmodule
